// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq -- MIPS FETCH-stage sequencer.
//
// Owns the program counter and issues instruction-memory requests over a
// req/ack handshake. Fetched words go to a registered valid/ready output slot.
// A one-entry skid buffer absorbs the word that arrives while decode is
// stalled. Jump, branch and register-jump redirects reload the PC and squash
// wrong-path words, including a request that is still in flight.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req / imem_addr          fetch request and word-aligned address
//   imem_ack / imem_rdata         memory response (valid while imem_req)
//   if_valid / if_instr / if_pc4  output slot to decode
//   if_ready                      decode accepts the slot this cycle
//   jump_valid/target/pc4         J/JAL redirect
//   br_valid/imm/pc4              taken-branch redirect
//   jr_valid / jr_target          JR/JALR redirect
// ---------------------------------------------------------------------------
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    input  logic        if_ready,
    input  logic        jump_valid,
    input  logic [27:0] jump_target,
    input  logic [31:0] jump_pc4,
    input  logic        br_valid,
    input  logic [15:0] br_imm,
    input  logic [31:0] br_pc4,
    input  logic        jr_valid,
    input  logic [31:0] jr_target
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // requesting (req drops only right after reset)
        ST_STALL = 2'd1,   // skid full, no request
        ST_DRAIN = 2'd2    // in-flight wrong-path request, result discarded
    } state_e;

    // Region-relative jump: upper nibble of PC+4 with the shifted index.
    function automatic logic [31:0] jump_addr(input logic [31:0] pc4,
                                              input logic [27:0] tgt);
        jump_addr = ((pc4 & 32'hF000_0000) | {4'h0, tgt}) & 32'hFFFF_FFFC;
    endfunction

    // PC-relative branch; the sum wraps modulo 2^32.
    function automatic logic [31:0] branch_addr(input logic [31:0] pc4,
                                                input logic [15:0] imm);
        branch_addr = (pc4 + {{14{imm[15]}}, imm, 2'b00}) & 32'hFFFF_FFFC;
    endfunction

    // Register jump with the low two bits forced to zero.
    function automatic logic [31:0] jr_addr(input logic [31:0] tgt);
        jr_addr = tgt & 32'hFFFF_FFFC;
    endfunction

    state_e      state_q;
    logic        req_q;
    logic [31:0] addr_q;        // address on the bus (held through DRAIN)
    logic [31:0] pc_q;          // next fetch PC; pending target during DRAIN
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc4_q;

    logic        redir;
    logic [31:0] redir_target;
    logic [31:0] addr_plus4;

    assign redir      = jr_valid | jump_valid | br_valid;
    assign addr_plus4 = addr_q + 32'd4;

    // Redirect target selection, priority jr > jump > branch.
    always_comb begin
        redir_target = 32'h0000_0000;
        if (jr_valid) begin
            redir_target = jr_addr(jr_target);
        end else if (jump_valid) begin
            redir_target = jump_addr(jump_pc4, jump_target);
        end else if (br_valid) begin
            redir_target = branch_addr(br_pc4, br_imm);
        end else begin
            redir_target = 32'h0000_0000;
        end
    end

    // Fetch FSM with PC, output slot and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            pc4_q        <= 32'h0000_0000;
            skid_instr_q <= 32'h0000_0000;
            skid_pc4_q   <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (redir) begin
                        // Slot is squashed even if decode takes it this cycle.
                        valid_q <= 1'b0;
                        pc_q    <= redir_target;
                        if (req_q && !imem_ack) begin
                            // Keep the bus stable until the stale ack arrives.
                            state_q <= ST_DRAIN;
                        end else begin
                            addr_q  <= redir_target;
                            req_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end else if (req_q && imem_ack) begin
                        addr_q <= addr_plus4;
                        pc_q   <= addr_plus4;
                        if (!valid_q || if_ready) begin
                            valid_q <= 1'b1;
                            instr_q <= imem_rdata;
                            pc4_q   <= addr_plus4;
                        end else begin
                            skid_instr_q <= imem_rdata;
                            skid_pc4_q   <= addr_plus4;
                            req_q        <= 1'b0;
                            state_q      <= ST_STALL;
                        end
                    end else begin
                        // Also raises req in the first cycle after reset.
                        req_q <= 1'b1;
                        if (if_ready) begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (redir) begin
                        valid_q <= 1'b0;
                        pc_q    <= redir_target;
                        addr_q  <= redir_target;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (if_ready) begin
                        valid_q <= 1'b1;
                        instr_q <= skid_instr_q;
                        pc4_q   <= skid_pc4_q;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    valid_q <= 1'b0;
                    if (redir) begin
                        pc_q <= redir_target;
                    end
                    if (imem_ack) begin
                        // A redirect in the ack cycle wins over the older target.
                        addr_q  <= redir ? redir_target : pc_q;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc4    = pc4_q;

endmodule

// File: tb/tb_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_fetch_seq -- directed bench for fetch_seq.
// The memory returns rdata equal to the address. Every word that must reach
// decode is pushed into a queue when it is acked; the slot is compared with
// the queue head each cycle and popped when decode takes it.
// ---------------------------------------------------------------------------
module tb_fetch_seq;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_ready;
    logic        jump_valid;
    logic [27:0] jump_target;
    logic [31:0] jump_pc4;
    logic        br_valid;
    logic [15:0] br_imm;
    logic [31:0] br_pc4;
    logic        jr_valid;
    logic [31:0] jr_target;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];      // {instr, pc4}
    logic        draining  = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    fetch_seq #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .if_ready(if_ready),
        .jump_valid(jump_valid), .jump_target(jump_target), .jump_pc4(jump_pc4),
        .br_valid(br_valid), .br_imm(br_imm), .br_pc4(br_pc4),
        .jr_valid(jr_valid), .jr_target(jr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"},  imem_addr, RPC);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_instr"}, if_instr, 32'd0);
        check({tag, "_pc4"},   if_pc4, 32'd0);
    endtask

    // One clock cycle: drive memory/decode, check the slot, update the model.
    task automatic step(input logic ack, input logic rdy);
        logic redir;
        redir      = jump_valid | br_valid | jr_valid;
        imem_ack   = ack;
        if_ready   = rdy;
        imem_rdata = imem_addr;
        #1;
        if (pend) begin
            check("hs_req",  {31'd0, imem_req}, 32'd1);
            check("hs_addr", imem_addr, pend_addr);
        end
        if (if_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", if_instr, 32'hDEAD_0000);
            end else begin
                check("if_instr", if_instr, exp_q[0][63:32]);
                check("if_pc4",   if_pc4,   exp_q[0][31:0]);
                if (rdy) void'(exp_q.pop_front());
            end
        end
        if (redir) exp_q.delete();
        if (imem_req && ack && !redir && !draining)
            exp_q.push_back({imem_addr, imem_addr + 32'd4});
        if (draining && imem_req && ack) draining = 1'b0;
        else if (redir && imem_req && !ack) draining = 1'b1;
        pend      = imem_req && !ack;
        pend_addr = imem_addr;
        @(posedge clk);
        #1;
        jump_valid = 1'b0;
        br_valid   = 1'b0;
        jr_valid   = 1'b0;
        imem_ack   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b1;
        jump_valid = 1'b0; jump_target = 28'h0; jump_pc4 = 32'h0;
        br_valid = 1'b0; br_imm = 16'h0; br_pc4 = 32'h0;
        jr_valid = 1'b0; jr_target = 32'h0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        check("post_reset_req",  {31'd0, imem_req}, 32'd1);
        check("post_reset_addr", imem_addr, RPC);

        // Streaming: valid from the cycle after the first ack, continuously
        step(1'b1, 1'b1);
        check("first_valid", {31'd0, if_valid}, 32'd1);
        check("first_instr", if_instr, RPC);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            check("stream_valid", {31'd0, if_valid}, 32'd1);
        end
        check("stream_addr", imem_addr, 32'h0040_001C);

        // Backpressure: three cycles of if_ready=0 under continuous ack
        step(1'b1, 1'b0);
        check("stall_req0", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0);
        check("stall_req1", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0);
        check("stall_req2", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b1);
        check("unstall_valid", {31'd0, if_valid}, 32'd1);
        check("unstall_req",   {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Jump
        jump_valid = 1'b1; jump_pc4 = 32'h1000_0008; jump_target = 28'h123_4564;
        step(1'b1, 1'b1);
        check("jump_addr",  imem_addr, 32'h1123_4564);
        check("jump_req",   {31'd0, imem_req}, 32'd1);
        check("jump_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b1);
        check("jump_resume", {31'd0, if_valid}, 32'd1);
        step(1'b1, 1'b1);

        // Branch to 0xFFFF_FFFC, then PC wrap to 0
        br_valid = 1'b1; br_pc4 = 32'h0000_0004; br_imm = 16'hFFFE;
        step(1'b1, 1'b1);
        check("br_addr",  imem_addr, 32'hFFFF_FFFC);
        check("br_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_pc4",  if_pc4, 32'h0000_0000);
        step(1'b1, 1'b1);

        // Priority: jr beats jump and branch in the same cycle
        jr_valid = 1'b1; jr_target = 32'h0000_0103;
        jump_valid = 1'b1; jump_pc4 = 32'h1000_0008; jump_target = 28'h123_4564;
        br_valid = 1'b1; br_pc4 = 32'h0000_0004; br_imm = 16'hFFFE;
        step(1'b1, 1'b1);
        check("prio_addr", imem_addr, 32'h0000_0100);
        step(1'b1, 1'b1);

        // Drain: request to 0x0040_0010 waits 3 cycles, redirected twice
        jr_valid = 1'b1; jr_target = 32'h0040_0010;
        step(1'b1, 1'b1);
        check("drain_setup", imem_addr, 32'h0040_0010);
        step(1'b0, 1'b1);
        jr_valid = 1'b1; jr_target = 32'h0000_2000;
        step(1'b0, 1'b1);
        check("drain_hold0", imem_addr, 32'h0040_0010);
        br_valid = 1'b1; br_pc4 = 32'h0000_3000; br_imm = 16'h0004;
        step(1'b0, 1'b1);
        check("drain_hold1", imem_addr, 32'h0040_0010);
        check("drain_req",   {31'd0, imem_req}, 32'd1);
        step(1'b1, 1'b1);
        check("drain_target",  imem_addr, 32'h0000_3010);
        check("drain_discard", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b1);
        check("drain_resume", if_instr, 32'h0000_3010);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        exp_q.delete();
        draining = 1'b0;
        pend     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        check("rearm_addr", imem_addr, RPC);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("rearm_instr", if_instr, RPC + 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer for the MIPS FETCH stage. Owns the program counter and issues instruction-memory requests with a req/ack handshake. Presents fetched instructions to decode through a valid/ready output slot backed by a one-entry skid buffer. Applies control-flow redirects (26-bit jump targets already shifted by two, PC-relative branches, register jumps) and squashes wrong-path fetches, including any request still in flight.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address; always word-aligned.
- imem_ack  in  1  memory returns imem_rdata this cycle; legal in the same cycle req rises.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- if_valid  out  1  output slot holds an instruction.
- if_instr  out  32  instruction word.
- if_pc4  out  32  PC of if_instr plus 4.
- if_ready  in  1  decode accepts the slot this cycle.
- jump_valid  in  1  J/JAL redirect, one-cycle pulse.
- jump_target  in  28  {instr_index, 2'b00} from the jump shifter.
- jump_pc4  in  32  PC+4 of the jump instruction.
- br_valid  in  1  taken-branch redirect, one-cycle pulse.
- br_imm  in  16  branch immediate, signed word offset.
- br_pc4  in  32  PC+4 of the branch.
- jr_valid  in  1  JR/JALR redirect, one-cycle pulse.
- jr_target  in  32  register target.

## Operation
- States: FETCH (imem_req=1), STALL (imem_req=0, skid full), DRAIN (imem_req=1, result discarded).
- Target arithmetic:
  - jump: {jump_pc4[31:28], jump_target}.
  - branch: br_pc4 + (sign_extend(br_imm) << 2), mod 2^32.
  - jr: {jr_target[31:2], 2'b00}.
- Redirect priority when more than one pulses in a cycle: jr > jump > branch.
- FETCH, ack, no redirect: pc <= pc+4. The word goes to the output slot if the slot is empty or if_ready=1. Otherwise it goes to skid and the state moves to STALL.
- STALL: on if_ready the skid word moves to the slot and the state returns to FETCH.
- Any redirect:
  - if_valid clears next cycle and skid empties.
  - pc <= target.
  - If a request is outstanding (FETCH, req=1, ack=0), go to DRAIN. DRAIN holds imem_addr stable, discards the acked word, then goes to FETCH.
  - Otherwise go to FETCH. An ack in the redirect cycle is discarded.
- A redirect during DRAIN updates the pending target. The in-flight word is still discarded, and the drain still completes first.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay constant until the ack cycle.
- if_instr and if_pc4 stay stable while if_valid && !if_ready, unless a redirect occurs.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0.
  - pc=RESET_PC, skid empty, state FETCH.
  - imem_req rises in the first cycle after rst_n deasserts.
- rst_n asserted mid-operation: all of the above immediately, asynchronously. Outstanding requests are abandoned; memory must tolerate this.
- Latency: ack in cycle N gives if_valid in cycle N+1. Zero-wait memory with if_ready=1 sustains one instruction per cycle.
- Redirect in cycle N gives imem_addr=target with req=1 in cycle N+1 when nothing is outstanding. With a request outstanding, imem_addr=target in the cycle after the drain ack.
- Redirect and if_ready in the same cycle: the slot is consumed by decode, then invalidated.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=32'h0040_0000 -> all outputs at reset values. After release -> imem_req=1, imem_addr=32'h0040_0000.
- Streaming: ack every cycle with rdata=address -> if_valid continuous from the cycle after the first ack; if_instr=32'h0040_0000, 32'h0040_0004, …; if_pc4 = instr+4.
- Backpressure: if_ready=0 for 3 cycles under continuous ack -> exactly one word in skid, imem_req=0 in STALL, no word lost or duplicated after if_ready returns.
- Jump: jump_pc4=32'h1000_0008, jump_target=28'h0123_4564 -> next imem_addr=32'h1123_4564, if_valid=0 for one cycle.
- Branch wrap and priority:
  - br_pc4=32'h0000_0004, br_imm=16'hFFFE -> imem_addr=32'hFFFF_FFFC.
  - Same cycle with jr_valid, jr_target=32'h0000_0103 -> imem_addr=32'h0000_0100.
- Drain: redirect while a request to 32'h0040_0010 waits 3 cycles for ack -> address stays 32'h0040_0010 until ack, that word is never presented, then fetch resumes at the target.
